alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts.
// Ports: clk, rst, ALUA/ALUB/ALUFlagIn/ALUControl + in_valid/in_ready in; ALUResult/flags + out_valid/out_ready out.
module alu_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ALUA,
  input  logic [N-1:0] ALUB,
  input  logic         ALUFlagIn,
  input  logic [3:0]   ALUControl,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] ALUResult,
  output logic         ALUFlagC,
  output logic         ALUFlagZ,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [N-1:0] N_V = N'(N);
  localparam logic [N-1:0] ONE = N'(1);

  state_t       state;
  logic [N-1:0] work;
  logic [N-1:0] k;
  logic         left;
  logic         fill;
  logic         sat;
  logic         sat_c;

  logic [N-1:0] x;
  logic [N:0]   sum;
  logic [N-1:0] r;
  logic         c;
  logic         is_shift;
  logic [N-1:0] k_in;
  logic [N-1:0] nw;
  logic         nc;

  assign in_ready = (state == IDLE) && !rst;
  assign is_shift = (ALUControl == 4'd8) || (ALUControl == 4'd9);
  assign k_in     = (ALUB >= N_V) ? N_V : ALUB;

  // Single-cycle ops, evaluated on the live inputs at acceptance.
  always_comb begin
    x   = ALUFlagIn ? ALUB : ALUA;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    case (ALUControl)
      4'd0: r = ALUA & ALUB;
      4'd1: r = ALUA | ALUB;
      4'd2: begin
        sum = {1'b0, ALUA} + {1'b0, ALUB}
            + {{N{1'b0}}, ALUFlagIn};
        {c, r} = sum;
      end
      4'd3: begin
        r = x + ONE;
        c = &x;
      end
      4'd4: begin
        r = x - ONE;
        c = ~|x;
      end
      4'd5: r = ~x;
      4'd6: begin
        sum = {1'b0, ALUA} + {1'b0, ~ALUB}
            + {{N{1'b0}}, ALUFlagIn};
        {c, r} = sum;
      end
      4'd7: r = ALUA ^ ALUB;
      default: begin
        r = '0;
        c = 1'b0;
      end
    endcase
  end

  // One-bit shift step of the working register.
  always_comb begin
    if (left) begin
      nw = {work[N-2:0], fill};
      nc = work[N-1];
    end else begin
      nw = {fill, work[N-1:1]};
      nc = work[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ALUResult <= '0;
      ALUFlagC  <= 1'b0;
      ALUFlagZ  <= 1'b0;
      out_valid <= 1'b0;
      work      <= '0;
      k         <= '0;
      left      <= 1'b0;
      fill      <= 1'b0;
      sat       <= 1'b0;
      sat_c     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && k_in != '0) begin
              work  <= ALUA;
              k     <= k_in;
              left  <= (ALUControl == 4'd8);
              fill  <= ALUFlagIn;
              sat   <= (ALUB >= N_V);
              // Saturated shifts report the edge bit of A.
              sat_c <= (ALUControl == 4'd8) ?
                       ALUA[N-1] : ALUA[0];
              state <= SHIFT;
            end else if (is_shift) begin
              ALUResult <= ALUA;
              ALUFlagC  <= 1'b0;
              ALUFlagZ  <= ~|ALUA;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              ALUResult <= r;
              ALUFlagC  <= c;
              ALUFlagZ  <= ~|r;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= nw;
          k    <= k - ONE;
          if (k == ONE) begin
            ALUResult <= nw;
            ALUFlagC  <= sat ? sat_c : nc;
            ALUFlagZ  <= ~|nw;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=4).
// Table of directed ops plus hand sequences for hold and mid-shift reset.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ALUA;
  logic [3:0] ALUB;
  logic       ALUFlagIn;
  logic [3:0] ALUControl;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ALUResult;
  logic       ALUFlagC;
  logic       ALUFlagZ;
  logic       out_valid;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.N(4)) dut (
    .clk(clk),
    .rst(rst),
    .ALUA(ALUA),
    .ALUB(ALUB),
    .ALUFlagIn(ALUFlagIn),
    .ALUControl(ALUControl),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ALUResult(ALUResult),
    .ALUFlagC(ALUFlagC),
    .ALUFlagZ(ALUFlagZ),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       fin;
    logic [3:0] r;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic add(input string name,
                     input logic [3:0] op, a, b,
                     input logic fin,
                     input logic [3:0] r,
                     input logic c, z,
                     input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.fin = fin; v.r = r; v.c = c; v.z = z;
    v.lat = lat;
    tbl.push_back(v);
  endtask

  // Accept one request; afterwards scramble the inputs
  // and keep in_valid high, which must have no effect.
  task automatic accept(input logic [3:0] op, a, b,
                        input logic fin, input string name);
    @(negedge clk);
    ALUControl = op;
    ALUA = a;
    ALUB = b;
    ALUFlagIn = fin;
    in_valid = 1'b1;
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    ALUControl = 4'($urandom);
    ALUA = 4'($urandom);
    ALUB = 4'($urandom);
    ALUFlagIn = 1'($urandom);
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    accept(v.op, v.a, v.b, v.fin, v.name);
    repeat (20) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    chk({v.name, "_done"}, got, 1);
    chk({v.name, "_lat"}, lat, v.lat);
    chk({v.name, "_r"}, ALUResult, v.r);
    chk({v.name, "_c"}, ALUFlagC, v.c);
    chk({v.name, "_z"}, ALUFlagZ, v.z);
    chk({v.name, "_busy"}, in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.name, "_ov_drop"}, out_valid, 0);
    chk({v.name, "_idle"}, in_ready, 1);
    chk({v.name, "_retain"}, ALUResult, v.r);
  endtask

  initial begin
    bit seen;
    vec_t v;

    add("add_wrap", 2, 4'hF, 4'h1, 0, 4'h0, 1, 1, 1);
    add("sub_eq",   6, 4'h5, 4'h5, 1, 4'h0, 1, 1, 1);
    add("sub_brw",  6, 4'h3, 4'h5, 1, 4'hE, 0, 0, 1);
    add("add_cin",  2, 4'h3, 4'h4, 1, 4'h8, 0, 0, 1);
    add("and",      0, 4'hC, 4'hA, 0, 4'h8, 0, 0, 1);
    add("or",       1, 4'hC, 4'hA, 1, 4'hE, 0, 0, 1);
    add("illegal",  12, 4'hF, 4'hF, 1, 4'h0, 0, 1, 1);
    add("xor",      7, 4'hC, 4'hA, 0, 4'h6, 0, 0, 1);
    add("inc_a",    3, 4'hF, 4'h2, 0, 4'h0, 1, 1, 1);
    add("inc_b",    3, 4'h0, 4'h7, 1, 4'h8, 0, 0, 1);
    add("dec_a",    4, 4'h0, 4'h9, 0, 4'hF, 1, 0, 1);
    add("dec_b",    4, 4'h6, 4'h1, 1, 4'h0, 0, 1, 1);
    add("not_a",    5, 4'h5, 4'h0, 0, 4'hA, 0, 0, 1);
    add("not_b",    5, 4'h5, 4'hF, 1, 4'h0, 0, 1, 1);
    add("illeg15",  15, 4'h1, 4'h2, 0, 4'h0, 0, 1, 1);
    add("sl_2",     8, 4'b1011, 4'd2, 0, 4'b1100, 0, 0, 3);
    add("sr_sat",   9, 4'b1011, 4'd7, 1, 4'b1111, 1, 0, 5);
    add("sl_0",     8, 4'b1011, 4'd0, 1, 4'b1011, 0, 0, 1);
    add("sr_1",     9, 4'b0110, 4'd1, 0, 4'b0011, 0, 0, 2);
    add("sr_1f",    9, 4'b0101, 4'd1, 1, 4'b1010, 1, 0, 2);
    add("sl_3f",    8, 4'b0100, 4'd3, 1, 4'b0111, 0, 0, 4);
    add("sl_sat",   8, 4'b0001, 4'd5, 0, 4'b0000, 0, 1, 5);
    add("sl_4",     8, 4'b1001, 4'd4, 0, 4'b0000, 1, 1, 5);

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ALUA = '0;
    ALUB = '0;
    ALUFlagIn = 1'b0;
    ALUControl = '0;
    repeat (2) @(negedge clk);
    chk("rst_r", ALUResult, 0);
    chk("rst_c", ALUFlagC, 0);
    chk("rst_z", ALUFlagZ, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ir", in_ready, 1);

    foreach (tbl[i]) run_op(tbl[i]);

    // Result held while the consumer stalls.
    accept(2, 4'h2, 4'h3, 0, "hold");
    @(negedge clk);
    chk("hold_ov", out_valid, 1);
    chk("hold_r0", ALUResult, 4'h5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      ALUA = 4'($urandom);
      ALUB = 4'($urandom);
      ALUControl = 4'($urandom);
      #1;
      chk("hold_r", ALUResult, 4'h5);
      chk("hold_c", ALUFlagC, 0);
      chk("hold_z", ALUFlagZ, 0);
      chk("hold_ovs", out_valid, 1);
      chk("hold_ir", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold_rel_ov", out_valid, 0);
    chk("hold_rel_ir", in_ready, 1);
    chk("hold_rel_r", ALUResult, 4'h5);
    @(negedge clk);
    chk("hold_noacc", out_valid, 0);

    // Reset in the middle of a shift.
    accept(8, 4'hF, 4'd4, 1, "rst_shift");
    @(negedge clk);
    chk("rs_ov_shift", out_valid, 0);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rs_r", ALUResult, 0);
    chk("rs_c", ALUFlagC, 0);
    chk("rs_z", ALUFlagZ, 0);
    chk("rs_ov", out_valid, 0);
    chk("rs_ir", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rs_rel_ir", in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("rs_no_pulse", seen, 0);

    v.name = "post_rst_add";
    v.op = 2; v.a = 4'h3; v.b = 4'h4; v.fin = 1;
    v.r = 4'h8; v.c = 0; v.z = 0; v.lat = 1;
    run_op(v);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
